// File: rtl/schedw.sv
// schedw: phase scheduler for the multicycle core.
// Memory phases stretch with wait states and bus ready; run/halt/step control.
module schedw #(
  parameter int WS_WIDTH  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic [WS_WIDTH-1:0]  mem_ws,
  input  logic                 mem_acc,
  input  logic                 mem_ready,
  output logic                 phf,
  output logic                 phe,
  output logic                 phm,
  output logic                 phw,
  output logic                 ph_last,
  output logic [2:0]           clk_stat,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_HALT,
    S_F,
    S_E,
    S_M,
    S_W
  } state_t;

  localparam logic [WS_WIDTH-1:0] WS_ONE =
    {{(WS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [WS_WIDTH-1:0]  r_cnt;
  logic                 r_acc;
  logic                 r_step;
  logic [CNT_WIDTH-1:0] r_inst;

  logic       w_zero;
  logic       w_rdy;
  logic       w_last;
  logic       w_mem;
  logic       w_go;
  logic [1:0] w_idx;

  assign w_zero = (r_cnt == '0);
  // a non-accessing MEM phase never waits on the bus
  assign w_rdy  = mem_ready | ((r_state == S_M) & ~r_acc);
  assign w_mem  = (r_state == S_F) | (r_state == S_M);
  assign w_go   = run | (r_step & run);

  always_comb begin
    w_last = 1'b0;
    w_idx  = 2'd0;
    case (r_state)
      S_F: begin
        w_last = w_zero & w_rdy;
        w_idx  = 2'd0;
      end
      S_E: begin
        w_last = 1'b1;
        w_idx  = 2'd1;
      end
      S_M: begin
        w_last = w_zero & w_rdy;
        w_idx  = 2'd2;
      end
      S_W: begin
        w_last = 1'b1;
        w_idx  = 2'd3;
      end
      default: begin
        w_last = 1'b0;
        w_idx  = 2'd0;
      end
    endcase
  end

  assign phf      = (r_state == S_F);
  assign phe      = (r_state == S_E);
  assign phm      = (r_state == S_M);
  assign phw      = (r_state == S_W);
  assign halted   = (r_state == S_HALT);
  assign ph_last  = w_last;
  assign clk_stat = {halted | (w_mem & ~w_last), w_idx};
  assign inst_cnt = r_inst;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_F;
      r_cnt   <= mem_ws;
      r_acc   <= 1'b0;
      r_step  <= 1'b0;
      r_inst  <= '0;
    end else begin
      case (r_state)
        S_F: begin
          if (!w_zero) r_cnt <= r_cnt - WS_ONE;
          if (w_last) r_state <= S_E;
        end
        S_E: begin
          r_state <= S_M;
          r_acc   <= mem_acc;
          r_cnt   <= mem_acc ? mem_ws : '0;
        end
        S_M: begin
          if (!w_zero) r_cnt <= r_cnt - WS_ONE;
          if (w_last) r_state <= S_W;
        end
        S_W: begin
          r_inst <= r_inst + CNT_ONE;
          r_step <= 1'b0;
          if (w_go) begin
            r_state <= S_F;
            r_cnt   <= mem_ws;
          end else begin
            r_state <= S_HALT;
          end
        end
        default: begin
          if (run | step) begin
            r_state <= S_F;
            r_cnt   <= mem_ws;
            r_step  <= step & ~run;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_schedw.sv
// tb_schedw: directed bench for schedw with a cycle model
// and hand-computed phase lengths and strobe values.
module tb_schedw;

  logic       clk = 1'b0;
  logic       reset, run, step, mem_acc, mem_ready;
  logic [3:0] mem_ws;
  logic       phf, phe, phm, phw, ph_last, halted;
  logic [2:0] clk_stat;
  logic [3:0] inst_cnt;

  int checks = 0;
  int errors = 0;

  schedw #(.WS_WIDTH(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .mem_ws(mem_ws), .mem_acc(mem_acc), .mem_ready(mem_ready),
    .phf(phf), .phe(phe), .phm(phm), .phw(phw),
    .ph_last(ph_last), .clk_stat(clk_stat),
    .halted(halted), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  // model: phase 0..3 = F,E,M,W; 4 = halted
  int m_ph = 0;
  int m_wait = 0;
  int m_cnt = 0;
  bit m_acc = 0;
  bit m_valid = 0;

  function automatic bit m_last();
    if (m_ph == 0) return (m_wait == 0) && mem_ready;
    if (m_ph == 2) return (m_wait == 0) && (mem_ready || !m_acc);
    if (m_ph == 1 || m_ph == 3) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit lst;
    logic [12:0] exp_v, got_v;
    if (reset) begin
      m_valid = 1;
      m_ph = 0;
      m_wait = int'(mem_ws);
      m_cnt = 0;
    end else if (m_valid) begin
      lst = m_last();
      if (m_ph == 0 || m_ph == 2) begin
        if (m_wait > 0) m_wait--;
        if (lst) m_ph++;
      end else if (m_ph == 1) begin
        m_ph = 2;
        m_acc = mem_acc;
        m_wait = mem_acc ? int'(mem_ws) : 0;
      end else if (m_ph == 3) begin
        m_cnt = (m_cnt + 1) % 16;
        if (run) begin
          m_ph = 0;
          m_wait = int'(mem_ws);
        end else m_ph = 4;
      end else if (run || step) begin
        m_ph = 0;
        m_wait = int'(mem_ws);
      end
    end
    #1;
    if (m_valid) begin
      lst = m_last();
      exp_v = {m_ph == 0, m_ph == 1, m_ph == 2, m_ph == 3, lst,
               (m_ph == 4) || ((m_ph == 0 || m_ph == 2) && !lst),
               (m_ph == 4) ? 2'd0 : 2'(m_ph),
               m_ph == 4, 4'(m_cnt)};
      got_v = {phf, phe, phm, phw, ph_last, clk_stat, halted, inst_cnt};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got=%b exp=%b", $time, got_v, exp_v);
      end
    end
  end

  task automatic lit(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic inst_len(output int len, output int c0,
                          output int c1, output int c2);
    bit sw;
    sw = 0;
    len = 0;
    c0 = clk_stat;
    c1 = 0;
    c2 = 0;
    while (!(sw && phf) && len < 200) begin
      sw |= phw;
      @(negedge clk);
      len++;
      if (len == 1) c1 = clk_stat;
      if (len == 2) c2 = clk_stat;
    end
  endtask

  initial begin
    int l, a, b, c, c0, n;
    int prev;
    bit wrap;
    reset = 1; run = 1; step = 0;
    mem_ws = 0; mem_acc = 1; mem_ready = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    lit("rst_phf", phf, 1);
    lit("rst_halted", halted, 0);
    lit("rst_cnt", inst_cnt, 0);
    for (int i = 0; i < 12; i++) begin
      lit("t1_stat", clk_stat, i % 4);
      lit("t1_last", ph_last, 1);
      @(negedge clk);
    end
    lit("t1_cnt", inst_cnt, 3);

    mem_ws = 2;
    inst_len(l, a, b, c);
    lit("t2_len_ws_m", l, 6);
    inst_len(l, a, b, c);
    lit("t2_len_acc", l, 8);
    lit("t2_f_stat0", a, 4);
    lit("t2_f_stat1", b, 4);
    lit("t2_f_stat2", c, 0);
    mem_acc = 0;
    inst_len(l, a, b, c);
    lit("t2_len_noacc", l, 6);
    mem_ws = 0; mem_acc = 1;
    inst_len(l, a, b, c);
    lit("t2_len_fws", l, 6);

    mem_ready = 0;
    #1;
    lit("t3_last0", ph_last, 0);
    lit("t3_stat0", clk_stat, 4);
    @(negedge clk);
    lit("t3_phf1", phf, 1);
    lit("t3_last1", ph_last, 0);
    @(negedge clk);
    lit("t3_phf2", phf, 1);
    mem_ready = 1;
    #1;
    lit("t3_last2", ph_last, 1);
    lit("t3_stat2", clk_stat, 0);
    @(negedge clk);
    lit("t3_phe", phe, 1);
    repeat (3) @(negedge clk);

    @(negedge clk);
    lit("t4_in_e", phe, 1);
    run = 0;
    @(negedge clk);
    lit("t4_m", phm, 1);
    @(negedge clk);
    lit("t4_w", phw, 1);
    @(negedge clk);
    lit("t4_halted", halted, 1);
    lit("t4_strobes", {phf, phe, phm, phw}, 0);
    lit("t4_stat", clk_stat, 4);
    c0 = inst_cnt;
    repeat (2) @(negedge clk);
    lit("t4_stay", halted, 1);
    step = 1;
    @(negedge clk);
    step = 0;
    lit("t4_step_f", phf, 1);
    @(negedge clk);
    lit("t4_step_e", phe, 1);
    step = 1;
    @(negedge clk);
    step = 0;
    @(negedge clk);
    lit("t4_step_w", phw, 1);
    @(negedge clk);
    lit("t4_rehalt", halted, 1);
    lit("t4_cnt", inst_cnt, (c0 + 1) % 16);
    repeat (3) @(negedge clk);
    lit("t4_no_queue", halted, 1);
    lit("t4_cnt2", inst_cnt, (c0 + 1) % 16);

    mem_ws = 3; mem_acc = 1; run = 1;
    @(negedge clk);
    lit("t5_f", phf, 1);
    repeat (4) @(negedge clk);
    lit("t5_e", phe, 1);
    repeat (2) @(negedge clk);
    lit("t5_m_wait", clk_stat, 6);
    reset = 1;
    mem_ws = 5;
    @(negedge clk);
    reset = 0;
    lit("t5_phf", phf, 1);
    lit("t5_cnt", inst_cnt, 0);
    lit("t5_stat", clk_stat, 4);
    n = 0;
    while (phf && n < 50) begin
      @(negedge clk);
      n++;
    end
    lit("t5_flen", n, 6);

    mem_ws = 0;
    repeat (3) @(negedge clk);
    lit("t6_cnt1", inst_cnt, 1);
    wrap = 0;
    prev = inst_cnt;
    repeat (64) begin
      @(negedge clk);
      if (prev == 15 && inst_cnt == 0) wrap = 1;
      prev = inst_cnt;
    end
    lit("t6_wrap", wrap, 1);
    lit("t6_final", inst_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
